// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
// Holds the FSM state encoding, the requester port indices and the default widths.
package dmem_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam int PORT_LSU = 0;
   localparam int PORT_DBG = 1;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational 2-way picker producing a one-hot grant.
// Ports: req0, req1 (requests), pointer (conflict winner), grant[1:0] (one-hot, bit N = port N).
module dmem_arb_pick (
   input  logic       req0,
   input  logic       req1,
   input  logic       pointer,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req0 && req1) begin
         grant = pointer ? 2'b10 : 2'b01;
      end else begin
         grant = {req1, req0};
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the LSU (port 0) and debug/DMA (port 1).
// Ports: clock, reset (sync, active-high); per-port req/we/addr/wdata in, gnt/rvalid/rdata out;
// busy; mem_read_enable/mem_write_enable/mem_address/mem_write_data out, mem_read_data in.
// Macro DMEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to port 0.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t            state;
   state_t            state_next;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              owner;
   logic              pointer;
   logic [1:0]        grant;

`ifdef DMEM_ARB_RR_EN
   // Pointer names the port that wins the next conflict; it moves off the port just granted.
   always_ff @(posedge clock) begin
      if (reset) begin
         pointer <= 1'b0;
      end else if (gnt0 || gnt1) begin
         pointer <= gnt0;
      end
   end
`else
   assign pointer = 1'b0;
`endif

   dmem_arb_pick u_pick (
      .req0    (req0),
      .req1    (req1),
      .pointer (pointer),
      .grant   (grant)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Everything is gated with ~reset so a reset cycle never grants or touches memory.
   always_comb begin
      state_next       = state;
      gnt0             = 1'b0;
      gnt1             = 1'b0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_write_data   = '0;
      unique case (state)
         ST_IDLE: begin
            if (!reset && (grant != 2'b00)) begin
               gnt0       = grant[0];
               gnt1       = grant[1];
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_next = ST_IDLE;
            if (!reset) begin
               mem_read_enable  = ~lat_we;
               mem_write_enable = lat_we;
               mem_address      = lat_addr;
               mem_write_data   = lat_wdata;
            end
         end
      endcase
   end

   assign busy = (state == ST_ACCESS);

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         owner     <= 1'(PORT_LSU);
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (gnt0 || gnt1) begin
            lat_we    <= gnt1 ? we1 : we0;
            lat_addr  <= gnt1 ? addr1 : addr0;
            lat_wdata <= gnt1 ? wdata1 : wdata0;
            owner     <= gnt1;
         end
         if (state == ST_ACCESS && !lat_we) begin
            if (owner == 1'(PORT_DBG)) begin
               rdata1  <= mem_read_data;
               rvalid1 <= 1'b1;
            end else begin
               rdata0  <= mem_read_data;
               rvalid0 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench for dmem_arbiter with a behavioural memory.
// Table rows give per-cycle inputs and expected outputs; extra sequences cover conflicts and streaming.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [31:0] rdata0, rdata1;
   logic        mem_read_enable, mem_write_enable;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   logic [31:0] mem [1024];

   int n_tests = 0;
   int n_fail  = 0;

   dmem_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .req0             (req0),
      .we0              (we0),
      .addr0            (addr0),
      .wdata0           (wdata0),
      .req1             (req1),
      .we1              (we1),
      .addr1            (addr1),
      .wdata1           (wdata1),
      .gnt0             (gnt0),
      .gnt1             (gnt1),
      .rvalid0          (rvalid0),
      .rvalid1          (rvalid1),
      .rdata0           (rdata0),
      .rdata1           (rdata1),
      .busy             (busy),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural 1024x32 memory: combinational read, write on the rising edge.
   assign mem_read_data = mem_read_enable ? mem[mem_address[9:0]] : 32'h0;
   always @(posedge clock) begin
      if (mem_write_enable) mem[mem_address[9:0]] <= mem_write_data;
   end

   typedef struct {
      logic        rst;
      logic        r0;
      logic        w0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        r1;
      logic        w1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [6:0]  flags;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } vec_t;

   vec_t vecs[$];

   // flags = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_read_enable, mem_write_enable}
   task automatic add(input logic rst, input logic r0, input logic w0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [6:0] flags, input logic [31:0] maddr,
                      input logic [31:0] mwdata, input logic [31:0] rd0,
                      input logic [31:0] rd1);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.flags = flags; v.maddr = maddr; v.mwdata = mwdata;
      v.rd0 = rd0; v.rd1 = rd1;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   logic [1:0] exp_conf [3];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
`ifdef DMEM_ARB_RR_EN
      exp_conf[0] = 2'b01; exp_conf[1] = 2'b10; exp_conf[2] = 2'b01;
`else
      exp_conf[0] = 2'b01; exp_conf[1] = 2'b01; exp_conf[2] = 2'b01;
`endif

      // reset state
      add(1, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 0,0);
      // port 0 write DEADBEEF to 0x10, then read it back
      add(0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 7'b1000000, 0,0, 0,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000101, 32'h10,32'hDEADBEEF, 0,0);
      add(0, 1,0,32'h10,0, 0,0,0,0, 7'b1000000, 0,0, 0,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000110, 32'h10,0, 0,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0010000, 0,0, 32'hDEADBEEF,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'hDEADBEEF,0);
      // both ports read in the same idle cycle, held until granted
      add(0, 1,0,32'h20,0, 1,0,32'h30,0, 7'b1000000, 0,0, 32'hDEADBEEF,0);
      add(0, 0,0,0,0, 1,0,32'h30,0, 7'b0000110, 32'h20,0, 32'hDEADBEEF,0);
      add(0, 0,0,0,0, 1,0,32'h30,0, 7'b0110000, 0,0, 32'hA5000020,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000110, 32'h30,0, 32'hA5000020,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0001000, 0,0, 32'hA5000020,32'hA5000030);
      // req1 raised during port 0's access cycle
      add(0, 1,0,32'h40,0, 0,0,0,0, 7'b1000000, 0,0, 32'hA5000020,32'hA5000030);
      add(0, 0,0,0,0, 1,0,32'h50,0, 7'b0000110, 32'h40,0, 32'hA5000020,32'hA5000030);
      add(0, 0,0,0,0, 1,0,32'h50,0, 7'b0110000, 0,0, 32'hA5000040,32'hA5000030);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000110, 32'h50,0, 32'hA5000040,32'hA5000030);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0001000, 0,0, 32'hA5000040,32'hA5000050);
      // full-width address pass-through: read 0x3FF, write 0x400
      add(0, 1,0,32'h3FF,0, 0,0,0,0, 7'b1000000, 0,0, 32'hA5000040,32'hA5000050);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000110, 32'h3FF,0, 32'hA5000040,32'hA5000050);
      add(0, 1,1,32'h400,32'hCAFEF00D, 0,0,0,0, 7'b1010000, 0,0, 32'hA50003FF,32'hA5000050);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000101, 32'h400,32'hCAFEF00D, 32'hA50003FF,32'hA5000050);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 32'hA50003FF,32'hA5000050);
      // reset during the access cycle of a write
      add(0, 1,1,32'h20,32'h12345678, 0,0,0,0, 7'b1000000, 0,0, 32'hA50003FF,32'hA5000050);
      add(1, 0,0,0,0, 0,0,0,0, 7'b0000100, 0,0, 32'hA50003FF,32'hA5000050);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000000, 0,0, 0,0);
      // confirm the dropped write never reached memory
      add(0, 0,0,0,0, 1,0,32'h20,0, 7'b0100000, 0,0, 0,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0000110, 32'h20,0, 0,0);
      add(0, 0,0,0,0, 0,0,0,0, 7'b0001000, 0,0, 0,32'hA5000020);

      idle_inputs();
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         reset  = vecs[i].rst;
         req0   = vecs[i].r0; we0 = vecs[i].w0;
         addr0  = vecs[i].a0; wdata0 = vecs[i].d0;
         req1   = vecs[i].r1; we1 = vecs[i].w1;
         addr1  = vecs[i].a1; wdata1 = vecs[i].d1;
         @(negedge clock);
         chk("flags", i,
             {25'h0, gnt0, gnt1, rvalid0, rvalid1, busy,
              mem_read_enable, mem_write_enable},
             {25'h0, vecs[i].flags});
         chk("mem_address", i, mem_address, vecs[i].maddr);
         chk("mem_write_data", i, mem_write_data, vecs[i].mwdata);
         chk("rdata0", i, rdata0, vecs[i].rd0);
         chk("rdata1", i, rdata1, vecs[i].rd1);
         @(posedge clock);
         #1;
      end

      // three back-to-back conflicts from a fresh reset
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req0 = 1'b1; we0 = 1'b0; addr0 = 32'h60;
         req1 = 1'b1; we1 = 1'b0; addr1 = 32'h70;
         @(negedge clock);
         chk("conflict_gnt", k, {30'h0, gnt1, gnt0}, {30'h0, exp_conf[k]});
         @(posedge clock);
         #1;
         req0 = 1'b0; req1 = 1'b0;
         @(negedge clock);
         @(posedge clock);
         #1;
      end

      // port 1 alone, requesting continuously
      do_reset();
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h5;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("p1_stream_gnt", k, {31'h0, gnt1}, {31'h0, (k % 2) == 0});
         chk("p1_stream_gnt0", k, {31'h0, gnt0}, 32'h0);
         chk("p1_stream_rvalid", k, {31'h0, rvalid1},
             {31'h0, (k >= 2) && ((k % 2) == 0)});
         @(posedge clock);
         #1;
      end
      chk("p1_stream_rdata", 0, rdata1, 32'hA5000005);
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
